// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard event port: register offsets,
// STATUS/CTRL bit positions and the queued event entry format.
package ps2_kbd_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_IRQ_EN    = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_FLUSH_BIT = 0;

  typedef struct packed {
    logic       ext;
    logic       pressed;
    logic [7:0] code;
  } kbd_entry_t;

  localparam int ENTRY_W = $bits(kbd_entry_t);

endpackage

// File: rtl/ps2_kbd_port_fifo.sv
// First-word-fall-through synchronous FIFO with flush; a push into a full
// FIFO is accepted when a pop happens on the same edge.
module sync_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_s, do_pop_s;

  assign empty     = (count_q == {CNT_W{1'b0}});
  assign full      = (count_q == CNT_W'(DEPTH));
  assign do_pop_s  = pop & ~empty & ~flush;
  assign do_push_s = push & (~full | do_pop_s) & ~flush;
  assign head      = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_port.sv
// Keyboard event FIFO with a 68000 register window and level interrupt.
// Optional: PS2_KBD_RELEASE_FILTER_EN drops key-release events.
module ps2_kbd_port
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        cs,
  input  logic        as_n,
  input  logic        rw,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic [1:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        irq
);

  logic             prev_tog_q, armed_q;
  logic             sel_q, bus_arm_q, rd_data_q;
  logic             irq_en_q, irq_en_d;
  logic             ovf_q, ovf_d;
  logic             irq_q;
  logic             sel_s, start_s, pop_req_s, wr_lo_s, flush_s, push_req_s, drop_s;
  logic             full_s, empty_s;
  logic [CNT_W-1:0] count_s;
  logic [ENTRY_W-1:0] head_s;
  kbd_entry_t       ev_s;
  logic [15:0]      stat_s;
  logic             unused_s;

  assign unused_s = ^{uds_n, din[15:4], din[1]};

  assign ev_s.ext     = ps2_key[8];
  assign ev_s.pressed = ps2_key[9];
  assign ev_s.code    = ps2_key[7:0];

`ifdef PS2_KBD_RELEASE_FILTER_EN
  assign push_req_s = armed_q & (ps2_key[10] ^ prev_tog_q) & ps2_key[9];
`else
  assign push_req_s = armed_q & (ps2_key[10] ^ prev_tog_q);
`endif

  // bus_arm_q blocks a select held across reset release from acting as a new access.
  assign sel_s     = cs & ~as_n;
  assign start_s   = sel_s & ~sel_q & bus_arm_q;
  assign pop_req_s = sel_q & ~sel_s & rd_data_q;
  assign wr_lo_s   = start_s & ~rw & ~lds_n;
  assign flush_s   = wr_lo_s & (addr == REG_CTRL) & din[CTRL_FLUSH_BIT];
  assign drop_s    = push_req_s & full_s & ~(pop_req_s & ~empty_s) & ~flush_s;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req_s),
    .pop     (pop_req_s),
    .flush   (flush_s),
    .wdata   (ev_s),
    .head    (head_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  always_comb begin
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    if (wr_lo_s && (addr == REG_STATUS)) begin
      irq_en_d = din[ST_IRQ_EN];
      if (din[ST_OVERFLOW]) ovf_d = 1'b0;
      else                  ovf_d = ovf_q;
    end else begin
      irq_en_d = irq_en_q;
    end
    if (drop_s) ovf_d = 1'b1;
    else        ovf_d = ovf_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_tog_q <= 1'b0;
      armed_q    <= 1'b0;
      sel_q      <= 1'b0;
      bus_arm_q  <= 1'b0;
      rd_data_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      prev_tog_q <= ps2_key[10];
      armed_q    <= 1'b1;
      sel_q      <= sel_s;
      if (!sel_s) bus_arm_q <= 1'b1;
      if (start_s)     rd_data_q <= rw & (addr == REG_DATA) & ~empty_s;
      else if (!sel_s) rd_data_q <= 1'b0;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_en_q & ~empty_s;
    end
  end

  always_comb begin
    stat_s                          = 16'h0000;
    stat_s[ST_NOT_EMPTY]            = ~empty_s;
    stat_s[ST_FULL]                 = full_s;
    stat_s[ST_OVERFLOW]             = ovf_q;
    stat_s[ST_IRQ_EN]               = irq_en_q;
    stat_s[ST_COUNT_LSB +: CNT_W]   = count_s;
  end

  always_comb begin
    case (addr)
      REG_DATA:   dout = empty_s ? 16'h0000 : {{(16-ENTRY_W){1'b0}}, head_s};
      REG_STATUS: dout = stat_s;
      default:    dout = 16'h0000;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_ps2_kbd_port.sv
// Table-driven bench for ps2_kbd_port: bus reads/writes and keyboard events
// applied at negative clock edges, outputs compared against hand-computed values.
module tb_ps2_kbd_port;

  typedef enum logic [2:0] {OP_EV, OP_RD, OP_WR, OP_WRU, OP_IRQ, OP_RDEV, OP_WREV} op_e;
  typedef struct {
    op_e         op;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
    logic [9:0]  ev;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        cs, as_n, rw, uds_n, lds_n;
  logic [1:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        irq;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  vec_t vq[$];
  vec_t v;
  logic [15:0] rd_val;

  ps2_kbd_port #(.FIFO_DEPTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_key (ps2_key),
    .cs      (cs),
    .as_n    (as_n),
    .rw      (rw),
    .uds_n   (uds_n),
    .lds_n   (lds_n),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  function automatic void add(op_e op, logic [1:0] a, logic [15:0] d,
                              logic [15:0] e, logic [9:0] ev);
    vec_t t;
    t.op = op; t.a = a; t.d = d; t.exp = e; t.ev = ev;
    vq.push_back(t);
  endfunction

  task automatic check(input string nm, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s #%0d: got %h, want %h", nm, idx, act, exp);
  endtask

  // Event word: entry bits {ext, pressed, code} mapped onto ps2_key[8], [9], [7:0].
  task automatic toggle(input logic [9:0] e);
    ps2_key = {~ps2_key[10], e[8], e[9], e[7:0]};
  endtask

  task automatic bus_rd(input logic [1:0] a, input bit tog, input logic [9:0] e,
                        output logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; as_n = 1'b0; rw = 1'b1; addr = a;
    @(negedge clk);
    d = dout;
    cs = 1'b0; as_n = 1'b1;
    if (tog) toggle(e);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d, input bit lo_off,
                        input bit tog, input logic [9:0] e);
    @(negedge clk);
    cs = 1'b1; as_n = 1'b0; rw = 1'b0; addr = a; din = d;
    lds_n = lo_off; uds_n = 1'b0;
    if (tog) toggle(e);
    @(negedge clk);
    cs = 1'b0; as_n = 1'b1; rw = 1'b1; lds_n = 1'b1; uds_n = 1'b1;
  endtask

  initial begin
    // Reset state and startup toggle, then byte-lane gating.
    add(OP_IRQ,  2'd0, 16'h0000, 16'h0000, 10'h000);
    add(OP_RD,   2'd1, 16'h0000, 16'h0000, 10'h000);
    add(OP_RD,   2'd0, 16'h0000, 16'h0000, 10'h000);
    add(OP_WRU,  2'd1, 16'h0008, 16'h0000, 10'h000);
    add(OP_RD,   2'd1, 16'h0000, 16'h0000, 10'h000);
    // Event and drain.
    add(OP_WR,   2'd1, 16'h0008, 16'h0000, 10'h000);
    add(OP_EV,   2'd0, 16'h0000, 16'h0000, 10'h375);
    add(OP_IRQ,  2'd0, 16'h0000, 16'h0000, 10'h000);
    add(OP_IRQ,  2'd0, 16'h0000, 16'h0001, 10'h000);
    add(OP_RD,   2'd1, 16'h0000, 16'h0109, 10'h000);
    add(OP_RD,   2'd0, 16'h0000, 16'h0375, 10'h000);
    add(OP_IRQ,  2'd0, 16'h0000, 16'h0001, 10'h000);
    add(OP_IRQ,  2'd0, 16'h0000, 16'h0000, 10'h000);
    add(OP_RD,   2'd1, 16'h0000, 16'h0008, 10'h000);
    // Fill to full, then overflow.
    for (int i = 1; i <= 16; i++) add(OP_EV, 2'd0, 16'h0000, 16'h0000, 10'h100 | 10'(i));
    add(OP_RD,   2'd1, 16'h0000, 16'h100B, 10'h000);
    add(OP_EV,   2'd0, 16'h0000, 16'h0000, 10'h111);
    add(OP_RD,   2'd1, 16'h0000, 16'h100F, 10'h000);
    add(OP_WR,   2'd1, 16'h0004, 16'h0000, 10'h000);
    add(OP_RD,   2'd1, 16'h0000, 16'h1003, 10'h000);
    add(OP_RD,   2'd2, 16'h0000, 16'h0000, 10'h000);
    add(OP_RD,   2'd3, 16'h0000, 16'h0000, 10'h000);
    add(OP_WR,   2'd0, 16'hFFFF, 16'h0000, 10'h000);
    add(OP_WR,   2'd3, 16'hFFFF, 16'h0000, 10'h000);
    add(OP_RD,   2'd1, 16'h0000, 16'h1003, 10'h000);
    // Push on the same edge as the pop while full.
    add(OP_RDEV, 2'd0, 16'h0000, 16'h0101, 10'h155);
    add(OP_RD,   2'd1, 16'h0000, 16'h1003, 10'h000);
    for (int i = 2; i <= 16; i++) add(OP_RD, 2'd0, 16'h0000, 16'h0100 | 16'(i), 10'h000);
    add(OP_RD,   2'd0, 16'h0000, 16'h0155, 10'h000);
    add(OP_RD,   2'd0, 16'h0000, 16'h0000, 10'h000);
    add(OP_RD,   2'd1, 16'h0000, 16'h0000, 10'h000);
    // Flush racing a push.
    for (int i = 1; i <= 5; i++) add(OP_EV, 2'd0, 16'h0000, 16'h0000, 10'h120 | 10'(i));
    add(OP_RD,   2'd1, 16'h0000, 16'h0501, 10'h000);
    add(OP_WREV, 2'd2, 16'h0001, 16'h0000, 10'h1AA);
    add(OP_RD,   2'd1, 16'h0000, 16'h0000, 10'h000);
    add(OP_RD,   2'd0, 16'h0000, 16'h0000, 10'h000);
    // Release event.
    add(OP_EV,   2'd0, 16'h0000, 16'h0000, 10'h01C);
`ifdef PS2_KBD_RELEASE_FILTER_EN
    add(OP_RD,   2'd1, 16'h0000, 16'h0000, 10'h000);
    add(OP_RD,   2'd0, 16'h0000, 16'h0000, 10'h000);
`else
    add(OP_RD,   2'd1, 16'h0000, 16'h0101, 10'h000);
    add(OP_RD,   2'd0, 16'h0000, 16'h001C, 10'h000);
`endif
    add(OP_RD,   2'd1, 16'h0000, 16'h0000, 10'h000);

    reset_n = 1'b0;
    ps2_key = 11'h41C;
    cs = 1'b0; as_n = 1'b1; rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    addr = 2'd0; din = 16'h0000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      case (v.op)
        OP_EV:   begin @(negedge clk); toggle(v.ev); end
        OP_IRQ:  begin @(negedge clk); check("irq", i, {15'd0, irq}, v.exp); end
        OP_RD:   begin bus_rd(v.a, 1'b0, v.ev, rd_val); check("read", i, rd_val, v.exp); end
        OP_RDEV: begin bus_rd(v.a, 1'b1, v.ev, rd_val); check("read_push", i, rd_val, v.exp); end
        OP_WR:   bus_wr(v.a, v.d, 1'b0, 1'b0, v.ev);
        OP_WRU:  bus_wr(v.a, v.d, 1'b1, 1'b0, v.ev);
        OP_WREV: bus_wr(v.a, v.d, 1'b0, 1'b1, v.ev);
        default: check("bad_op", i, 16'hDEAD, 16'h0000);
      endcase
    end

    // A STATUS write held across reset release must not take effect.
    @(negedge clk);
    cs = 1'b1; as_n = 1'b0; rw = 1'b0; lds_n = 1'b0; addr = 2'd1; din = 16'h0008;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    cs = 1'b0; as_n = 1'b1; rw = 1'b1; lds_n = 1'b1;
    bus_rd(2'd1, 1'b0, 10'h000, rd_val);
    check("held_write", 0, rd_val, 16'h0000);
    bus_wr(2'd1, 16'h0008, 1'b0, 1'b0, 10'h000);
    bus_rd(2'd1, 1'b0, 10'h000, rd_val);
    check("write_after_reset", 0, rd_val, 16'h0008);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
